parity_transmitter: RTL and testbench

Serial transmitter that converts an 8-bit parallel bus value into a UART-style frame with a parity bit on a single output line. Each frame is: start bit, 8 data bits LSB first, parity bit, stop bit. It sits between a byte-wide producer and a serial link. A valid/busy pair paces the producer.

---
 rtl/parity_transmitter_if.sv | 26 ++
 rtl/parity_transmitter.sv | 118 +++++++++++
 tb/tb_parity_transmitter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/parity_transmitter_if.sv
// Byte-wide producer side of the parity transmitter plus its serial-line outputs.
// Handshake: the producer holds data_valid with bus_value; a request is taken on a
// rising edge only while busy=0, busy rises the next cycle and requests are ignored until it falls.
interface parity_transmitter_if;
  logic [7:0] bus_value;
  logic       data_valid;
  logic       data_out;
  logic       busy;
  logic       tx_done;

  modport master (
    output bus_value,
    output data_valid,
    input  data_out,
    input  busy,
    input  tx_done
  );

  modport slave (
    input  bus_value,
    input  data_valid,
    output data_out,
    output busy,
    output tx_done
  );
endinterface

// File: rtl/parity_transmitter.sv
// UART-style serialiser: start bit, 8 data bits LSB first, parity bit, stop bit.
// All outputs are registered; state is exposed on state_dbg for checkers.
module parity_transmitter #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  parity_transmitter_if.slave  bus,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t          state;
  logic [CW-1:0]   cyc;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            parity_bit;
  logic            bit_end;

  assign bit_end   = (cyc == CNT_LAST);
  assign state_dbg = state;

  // data_out is loaded with the value of the state being entered, so the line
  // changes on the same edge as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cyc          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      parity_bit   <= 1'b0;
      bus.data_out <= 1'b1;
      bus.busy     <= 1'b0;
      bus.tx_done  <= 1'b0;
    end else begin
      bus.tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.data_valid) begin
            shreg        <= bus.bus_value;
            parity_bit   <= (^bus.bus_value) ^ PARITY_ODD;
            cyc          <= '0;
            bit_idx      <= '0;
            state        <= START;
            bus.data_out <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            cyc          <= '0;
            state        <= DATA;
            bus.data_out <= shreg[0];
          end else begin
            cyc <= cyc + CNT_ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx      <= '0;
              state        <= PARITY;
              bus.data_out <= parity_bit;
            end else begin
              bit_idx      <= bit_idx + 3'd1;
              shreg        <= {1'b0, shreg[7:1]};
              bus.data_out <= shreg[1];
            end
          end else begin
            cyc <= cyc + CNT_ONE;
          end
        end
        PARITY: begin
          if (bit_end) begin
            cyc          <= '0;
            state        <= STOP;
            bus.data_out <= 1'b1;
            // With one clock per bit the only stop cycle is also the last one.
            bus.tx_done  <= (CNT_LAST == '0);
          end else begin
            cyc <= cyc + CNT_ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            cyc      <= '0;
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            cyc         <= cyc + CNT_ONE;
            bus.tx_done <= ((cyc + CNT_ONE) == CNT_LAST);
          end
        end
        default: begin
          state        <= IDLE;
          cyc          <= '0;
          bit_idx      <= '0;
          bus.data_out <= 1'b1;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_transmitter.sv
// Bench for parity_transmitter: one instance at 1 clock/bit even parity,
// one at 4 clocks/bit odd parity; frames are checked against a queue of expected frames.
module tb_parity_transmitter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  parity_transmitter_if if0 ();
  parity_transmitter_if if1 ();
  logic [2:0] st0;
  logic [2:0] st1;

  parity_transmitter #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .bus       (if0.slave),
    .state_dbg (st0)
  );

  parity_transmitter #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (if1.slave),
    .state_dbg (st1)
  );

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame in transmission order: bit 0 is the start bit, bit 10 the stop bit.
  function automatic logic [10:0] frame_of(input logic [7:0] v, input logic odd);
    return {1'b1, (^v) ^ odd, v, 1'b0};
  endfunction

  function automatic logic dout_of(input int k);
    return (k == 0) ? if0.data_out : if1.data_out;
  endfunction

  function automatic logic busy_of(input int k);
    return (k == 0) ? if0.busy : if1.busy;
  endfunction

  function automatic logic done_of(input int k);
    return (k == 0) ? if0.tx_done : if1.tx_done;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input int k, input logic [7:0] v, input logic vld);
    if (k == 0) begin
      if0.bus_value  = v;
      if0.data_valid = vld;
    end else begin
      if1.bus_value  = v;
      if1.data_valid = vld;
    end
  endtask

  // Called at a falling edge while the DUT is idle.
  task automatic send(input int k, input logic [7:0] v);
    drive(k, v, 1'b1);
    exp_q.push_back(frame_of(v, (k == 1)));
    @(negedge clk);
    drive(k, v, 1'b0);
  endtask

  // Waits for busy, captures one frame, checks it against the queue head.
  task automatic watch(input int k, input int cpb, input bit chk_lat);
    int t = 0;
    int len = 0;
    int ndone = 0;
    int done_at = -1;
    int bad_hold = 0;
    int idx;
    logic [10:0] bits = '0;
    logic [10:0] exp;
    while (!busy_of(k) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!busy_of(k)) begin
      check("busy_start_timeout", 32'd0, 32'd1);
      return;
    end
    if (chk_lat) check("start_latency", t, 1);
    while (busy_of(k) && len < 200) begin
      idx = len / cpb;
      if (idx <= 10) begin
        if (len % cpb == 0) bits[idx] = dout_of(k);
        else if (dout_of(k) !== bits[idx]) bad_hold++;
      end
      if (done_of(k)) begin
        ndone++;
        done_at = len;
      end
      len++;
      @(negedge clk);
    end
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    exp = exp_q.pop_front();
    check("frame_bits", bits, exp);
    check("busy_len", len, 11 * cpb);
    check("tx_done_count", ndone, 1);
    check("tx_done_pos", done_at, len - 1);
    check("bit_hold", bad_hold, 0);
    check("idle_line", dout_of(k), 1'b1);
  endtask

  task automatic tx(input int k, input logic [7:0] v, input int cpb);
    fork
      send(k, v);
      watch(k, cpb, 1'b1);
    join
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] par_vals[4] = '{8'd45, 8'd9, 8'd67, 8'd101};

  initial begin
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);

    // Asynchronous reset, asserted between clock edges.
    #2 rst = 1'b1;
    #1;
    check("rst_dout0", if0.data_out, 1'b1);
    check("rst_busy0", if0.busy, 1'b0);
    check("rst_done0", if0.tx_done, 1'b0);
    check("rst_dout1", if1.data_out, 1'b1);
    check("rst_state1", st1, 3'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_hold", {if0.data_out, if1.data_out, if0.busy, if1.busy}, 4'b1100);
    end

    // Single 0x0C frame, 1 clock per bit, even parity.
    tx(0, 8'h0C, 1);

    // Parity coverage, even parity, back to back and random.
    foreach (par_vals[i]) tx(0, par_vals[i], 1);
    for (int i = 0; i < 4; i++) tx(0, 8'($urandom_range(0, 255)), 1);

    // Odd parity, 4 clocks per bit.
    tx(1, 8'd67, 4);
    tx(1, 8'h00, 4);
    tx(1, 8'($urandom_range(0, 255)), 4);

    // Mid-frame bus changes and data_valid pulses must not disturb the frame.
    fork
      watch(1, 4, 1'b1);
      begin
        send(1, 8'h0C);
        repeat (10) @(negedge clk);
        drive(1, 8'hFF, 1'b1);
        @(negedge clk);
        drive(1, 8'hFF, 1'b0);
      end
    join
    for (int i = 0; i < 5; i++) begin
      check("no_queued_frame", if1.busy, 1'b0);
      @(negedge clk);
    end

    // data_valid held through the stop bit: ignored there, taken one idle cycle later.
    drive(0, 8'h3C, 1'b1);
    exp_q.push_back(frame_of(8'h3C, 1'b0));
    fork
      begin
        watch(0, 1, 1'b1);
        watch(0, 1, 1'b1);
      end
      begin
        int w = 0;
        @(negedge clk);
        drive(0, 8'hA7, 1'b1);
        exp_q.push_back(frame_of(8'hA7, 1'b0));
        while (if0.busy && w < 40) begin
          @(negedge clk);
          w++;
        end
        @(negedge clk);
        drive(0, 8'hA7, 1'b0);
      end
    join

    // Reset during data bit 3 aborts the frame; a fresh frame follows.
    @(negedge clk);
    drive(1, 8'hA5, 1'b1);
    @(negedge clk);
    drive(1, 8'hA5, 1'b0);
    repeat (17) @(negedge clk);
    check("state_before_abort", st1, 3'd2);
    #2 rst = 1'b1;
    #1;
    check("abort_dout", if1.data_out, 1'b1);
    check("abort_busy", if1.busy, 1'b0);
    check("abort_state", st1, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_resume", {if1.data_out, if1.busy}, 2'b10);
    end
    tx(1, 8'h5A, 4);

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
